// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - frame accumulator for adder partial sums with show-ahead result FIFO
//
// Accumulates unsigned partial sums framed by first/last markers, modulo
// 2^ACC_WIDTH, and queues {result, term count} per completed frame.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   in_sum/in_valid         partial sum beat from the adder column
//   in_first/in_last        frame markers (may both be set on one beat)
//   in_ready                beat accepted when in_valid && in_ready
//   out_acc/out_count       FIFO head result and term count (0 when empty)
//   out_valid/out_ready     FIFO pop handshake
//   fifo_level              current FIFO occupancy
//   err_frame               sticky framing error, cleared only by reset
module psum_accumulator #(
  parameter int IN_WIDTH   = 19,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [IN_WIDTH-1:0]             in_sum,
  input  logic                            in_valid,
  input  logic                            in_first,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [ACC_WIDTH-1:0]            out_acc,
  output logic [CNT_WIDTH-1:0]            out_count,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            err_frame
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc, acc_next, sum_ext, push_acc;
  logic [CNT_WIDTH-1:0] count, count_next, count_inc, push_count;
  logic                 accept, push, pop, err_set;

  logic [ACC_WIDTH-1:0] mem_acc   [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] mem_count [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;

  // Handshake outputs come from the registered level only; no bypass when
  // full, so in_ready never depends on out_ready.
  assign in_ready   = (level != LW'(FIFO_DEPTH));
  assign out_valid  = (level != '0);
  assign fifo_level = level;
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  assign sum_ext    = ACC_WIDTH'(in_sum);
  assign count_inc  = (count == '1) ? count : count + CNT_WIDTH'(1);

  // Storage is not reset, so mask the head to keep outputs at 0 when empty.
  assign out_acc    = out_valid ? mem_acc[rd_ptr]   : '0;
  assign out_count  = out_valid ? mem_count[rd_ptr] : '0;

  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    push       = 1'b0;
    push_acc   = sum_ext;
    push_count = CNT_WIDTH'(1);
    err_set    = 1'b0;
    if (accept) begin
      if (in_first) begin
        // A first marker inside an open frame abandons the partial frame.
        err_set    = (state == ACCUM);
        acc_next   = sum_ext;
        count_next = CNT_WIDTH'(1);
        if (in_last) begin
          push       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = ACCUM;
        end
      end else if (state == ACCUM) begin
        acc_next   = acc + sum_ext;
        count_next = count_inc;
        if (in_last) begin
          push       = 1'b1;
          push_acc   = acc + sum_ext;
          push_count = count_inc;
          state_next = IDLE;
        end
      end else begin
        // Orphan beat with no open frame: dropped.
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      err_frame <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
      if (err_set) begin
        err_frame <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_acc[wr_ptr]   <= push_acc;
      mem_count[wr_ptr] <= push_count;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - scoreboard testbench for psum_accumulator
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [18:0] in_sum;
  logic        in_valid, in_first, in_last, in_ready;
  logic [31:0] out_acc;
  logic [15:0] out_count;
  logic        out_valid, out_ready;
  logic [2:0]  fifo_level;
  logic        err_frame;

  logic [18:0] w_in_sum;
  logic        w_in_valid, w_in_first, w_in_last, w_in_ready;
  logic [19:0] w_out_acc;
  logic [15:0] w_out_count;
  logic        w_out_valid, w_out_ready;
  logic [2:0]  w_fifo_level;
  logic        w_err_frame;

  int vectors = 0;
  int miscompares = 0;
  logic [47:0] sb[$];

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk(clk), .reset_n(reset_n), .in_sum(in_sum), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .in_ready(in_ready),
    .out_acc(out_acc), .out_count(out_count), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .err_frame(err_frame)
  );

  psum_accumulator #(.ACC_WIDTH(20)) dut_w (
    .clk(clk), .reset_n(reset_n), .in_sum(w_in_sum), .in_valid(w_in_valid),
    .in_first(w_in_first), .in_last(w_in_last), .in_ready(w_in_ready),
    .out_acc(w_out_acc), .out_count(w_out_count), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .fifo_level(w_fifo_level), .err_frame(w_err_frame)
  );

  // Scoreboard: every handshaken pop is compared against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got acc=%0d count=%0d, expected no output", out_acc, out_count);
      end else begin
        logic [47:0] exp_v;
        exp_v = sb.pop_front();
        if ({out_acc, out_count} !== exp_v) begin
          miscompares++;
          $display("FAIL output: got acc=%0d count=%0d, expected acc=%0d count=%0d",
                   out_acc, out_count, exp_v[47:16], exp_v[15:0]);
        end
      end
    end
  end

  task automatic send(input logic f, input logic l, input logic [18:0] s);
    int n;
    logic rdy;
    in_sum = s; in_first = f; in_last = l; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 64);
    if (!rdy) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_acc, out_count, fifo_level, err_frame} !==
        {1'b1, 1'b0, 32'd0, 16'd0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: got rdy=%0b vld=%0b acc=%0d cnt=%0d lvl=%0d err=%0b, expected 1 0 0 0 0 0",
               tag, in_ready, out_valid, out_acc, out_count, fifo_level, err_frame);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_values("reset_state");
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    out_ready = 1'b1;
    sb.push_back({32'd60, 16'd3});
    send(1, 0, 10); send(0, 0, 20); send(0, 1, 30);
    drain();
    vectors++;
    if (err_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_err: got %0b, expected 0", err_frame);
    end
  endtask

  task automatic test_wrap();
    logic [18:0] beats [3];
    int n;
    beats[0] = 19'd524287; beats[1] = 19'd524287; beats[2] = 19'd2;
    w_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_in_sum = beats[i]; w_in_first = (i == 0); w_in_last = (i == 2); w_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    w_in_valid = 1'b0; w_in_first = 1'b0; w_in_last = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!w_out_valid && n < 20);
    vectors++;
    if (!w_out_valid || w_out_acc !== 20'd0 || w_out_count !== 16'd3) begin
      miscompares++;
      $display("FAIL wrap: got vld=%0b acc=%0d count=%0d, expected 1 0 3", w_out_valid, w_out_acc, w_out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n;
    logic rdy;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back({32'(i), 16'd1});
      send(1, 1, 19'(i));
    end
    @(negedge clk);
    vectors++;
    if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full: got level=%0d in_ready=%0b, expected 4 0", fifo_level, in_ready);
    end
    @(posedge clk); #1;
    sb.push_back({32'd5, 16'd1});
    in_sum = 19'd5; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    vectors++;
    if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL held: got level=%0d in_ready=%0b, expected 4 0", fifo_level, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 20);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL fifth_accept: accepted at edge %0d after out_ready, expected 2", n);
    end
    drain();
  endtask

  task automatic test_orphan();
    out_ready = 1'b1;
    send(0, 1, 7);
    @(negedge clk);
    vectors++;
    if (err_frame !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL orphan: got err=%0b vld=%0b, expected 1 0", err_frame, out_valid);
    end
    @(posedge clk); #1;
    sb.push_back({32'd11, 16'd2});
    send(1, 0, 5); send(0, 1, 6);
    drain();
  endtask

  task automatic test_restart();
    do_reset();
    out_ready = 1'b1;
    send(1, 0, 3); send(0, 0, 4);
    vectors++;
    if (err_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_pre_err: got %0b, expected 0", err_frame);
    end
    sb.push_back({32'd101, 16'd2});
    send(1, 0, 100); send(0, 1, 1);
    drain();
    vectors++;
    if (err_frame !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_err: got %0b, expected 1", err_frame);
    end
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b0;
    send(1, 1, 50);
    send(1, 0, 9); send(0, 0, 9);
    reset_n = 1'b0;
    in_sum = 19'd77; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    check_reset_values("during_reset");
    reset_n = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    check_reset_values("after_reset");
    @(posedge clk); #1;
    out_ready = 1'b1;
    sb.push_back({32'd2, 16'd1});
    send(1, 1, 2);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int fr = 0; fr < 20; fr++) begin
      int len;
      logic [31:0] sum;
      logic [18:0] s;
      len = $urandom_range(1, 4);
      sum = 32'd0;
      for (int b = 0; b < len; b++) begin
        s = 19'($urandom);
        sum = sum + 32'(s);
        out_ready = 1'($urandom);
        if (b == len - 1) sb.push_back({sum, 16'(len)});
        send(b == 0, b == len - 1, s);
      end
    end
    out_ready = 1'b1;
    drain();
  endtask

  initial begin
    reset_n = 1'b0;
    in_sum = '0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    w_in_sum = '0; w_in_valid = 1'b0; w_in_first = 1'b0; w_in_last = 1'b0; w_out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic_frame();
    test_wrap();
    test_backpressure();
    test_orphan();
    test_restart();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
